// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
//
// Merges the per-stage stall requests into one hold vector. Accepts MEM-stage
// exceptions and turns each into a one-cycle flush with a redirect PC. Runs a
// watchdog that sets a sticky flag when the pipeline stays stalled too long.
//
// Ports:
//   clk                rising-edge clock
//   rst                synchronous active-high reset
//   stallreq_from_if   fetch memory not ready
//   stallreq_from_id   ID stage stall (load-use)
//   stallreq_from_ex   EX stage stall (multi-cycle mul/div)
//   stallreq_from_mem  MEM stage stall (data bus wait)
//   excepttype_i       exception code from MEM, 0 = none, held until flushed
//   cp0_epc_i          EPC from CP0, used as the eret target
//   stall              hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
//   flush              registered: clear pipeline registers, load new_pc into PC
//   new_pc             registered redirect target, meaningful only while flush=1
//   stall_timeout      registered sticky watchdog flag, cleared only by rst
module pipe_ctrl #(
    parameter logic [31:0] EBASE         = 32'h00000000,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
);

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } state_e;

    localparam logic [31:0] ExcInt  = 32'h00000001;
    localparam logic [31:0] ExcEret = 32'h0000000e;

    // 32-bit additions, wrap on overflow.
    localparam logic [31:0] IntVector = EBASE + 32'h00000020;
    localparam logic [31:0] ExcVector = EBASE + 32'h00000040;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STALL_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              flush_q, flush_d;
    logic [31:0]       new_pc_q, new_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;

    logic              except_accept;
    logic [31:0]       vector;

    // An exception waits while MEM is stalled: the faulting access has not
    // completed, so the pipeline cannot be redirected yet.
    assign except_accept = (state_q == StRun) && (excepttype_i != 32'h0)
                           && !stallreq_from_mem;

    always_comb begin
        vector = ExcVector;
        case (excepttype_i)
            ExcInt:  vector = IntVector;
            ExcEret: vector = cp0_epc_i;
            default: vector = ExcVector;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (except_accept) begin
                    state_d = StFlush;
                end
            end
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM: stall output. FLUSH and reset hold nothing.
    always_comb begin
        stall = 6'b000000;
        if (!rst && (state_q == StRun)) begin
            if (except_accept) begin
                stall = 6'b111111;
            end else if (stallreq_from_mem) begin
                stall = 6'b011111;
            end else if (stallreq_from_ex) begin
                stall = 6'b001111;
            end else if (stallreq_from_id || stallreq_from_if) begin
                stall = 6'b000111;
            end
        end
    end

    // Flush / redirect and watchdog next state
    always_comb begin
        flush_d  = except_accept;
        new_pc_d = except_accept ? vector : new_pc_q;

        cnt_d = '0;
        tmo_d = tmo_q;
        if ((state_q == StRun) && !except_accept && (stall != 6'b000000)) begin
            // Count parks at CntLast once reached, so it never wraps back.
            if (cnt_q == CntLast) begin
                tmo_d = 1'b1;
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q  <= 1'b0;
            new_pc_q <= 32'h00000000;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end

    assign flush         = flush_q;
    assign new_pc        = new_pc_q;
    assign stall_timeout = tmo_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam logic [31:0] EBASE   = 32'hBFC00200;
    localparam logic [31:0] INT_VEC = 32'hBFC00220;
    localparam logic [31:0] EXC_VEC = 32'hBFC00240;

    // Request encoding {mem, ex, id, if}
    localparam logic [3:0] R_NONE = 4'b0000;
    localparam logic [3:0] R_IF   = 4'b0001;
    localparam logic [3:0] R_ID   = 4'b0010;
    localparam logic [3:0] R_EX   = 4'b0100;
    localparam logic [3:0] R_MEM  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_from_if = 1'b0;
    logic        stallreq_from_id = 1'b0;
    logic        stallreq_from_ex = 1'b0;
    logic        stallreq_from_mem = 1'b0;
    logic [31:0] excepttype_i = 32'h0;
    logic [31:0] cp0_epc_i = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;

    pipe_ctrl #(
        .EBASE         (EBASE),
        .STALL_TIMEOUT (4),
        .CNT_W         (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .excepttype_i      (excepttype_i),
        .cp0_epc_i         (cp0_epc_i),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_timeout     (stall_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        tmo;
    } row_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic row_t mk(input logic r, input logic [3:0] req, input logic [31:0] exc,
                                input logic [31:0] epc, input logic [5:0] st, input logic fl,
                                input logic [31:0] pc, input logic tmo);
        row_t x;
        x.rst = r; x.req = req; x.exc = exc; x.epc = epc;
        x.stall = st; x.flush = fl; x.pc = pc; x.tmo = tmo;
        return x;
    endfunction

    // Drive one cycle of stimulus, queue its expected outputs, wait to the sample point.
    task automatic apply(input row_t r);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r.rst;
        {stallreq_from_mem, stallreq_from_ex, stallreq_from_id, stallreq_from_if} = r.req;
        excepttype_i = r.exc;
        cp0_epc_i    = r.epc;
        e.stall = r.stall; e.flush = r.flush; e.pc = r.pc; e.tmo = r.tmo;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        {stallreq_from_mem, stallreq_from_ex, stallreq_from_id, stallreq_from_if} = R_NONE;
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(0, R_NONE, 0, 0, 6'h00, 0, 32'h0, 0));
        rows.push_back(mk(0, R_NONE, 0, 0, 6'h00, 0, 32'h0, 0));
        rows.push_back(mk(1, R_MEM,  0, 0, 6'h00, 0, 32'h0, 0));  // rst masks stall
        rows.push_back(mk(0, R_NONE, 8, 0, 6'h3F, 0, 32'h0, 0));
        rows.push_back(mk(1, R_NONE, 8, 0, 6'h00, 1, EXC_VEC, 0)); // rst during FLUSH
        rows.push_back(mk(0, R_NONE, 0, 0, 6'h00, 0, 32'h0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc
                || stall_timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL reset[%0d]: got stall=%b flush=%b new_pc=%h tmo=%b, want stall=%b flush=%b new_pc=%h tmo=%b",
                         i, stall, flush, new_pc, stall_timeout, e.stall, e.flush, e.pc, e.tmo);
            end
        end
    endtask

    task automatic test_priority();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(0, R_ID,               0, 0, 6'h07, 0, 0, 0));
        rows.push_back(mk(0, R_ID | R_EX,        0, 0, 6'h0F, 0, 0, 0));
        rows.push_back(mk(0, R_ID | R_EX | R_MEM, 0, 0, 6'h1F, 0, 0, 0));
        rows.push_back(mk(0, R_NONE,             0, 0, 6'h00, 0, 0, 0));
        rows.push_back(mk(0, R_IF,               0, 0, 6'h07, 0, 0, 0));
        rows.push_back(mk(0, R_IF | R_MEM,       0, 0, 6'h1F, 0, 0, 0));
        rows.push_back(mk(0, R_IF | R_EX,        0, 0, 6'h0F, 0, 0, 0));
        rows.push_back(mk(0, R_NONE,             0, 0, 6'h00, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc
                || stall_timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL priority[%0d]: got stall=%b flush=%b new_pc=%h tmo=%b, want stall=%b flush=%b new_pc=%h tmo=%b",
                         i, stall, flush, new_pc, stall_timeout, e.stall, e.flush, e.pc, e.tmo);
            end
        end
    endtask

    task automatic test_syscall();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(0, R_NONE,       32'h8,    0, 6'h3F, 0, 32'h0, 0));
        rows.push_back(mk(0, R_MEM | R_EX, 32'h8,    0, 6'h00, 1, EXC_VEC, 0)); // ignored in FLUSH
        rows.push_back(mk(0, R_NONE,       0,        0, 6'h00, 0, EXC_VEC, 0));
        rows.push_back(mk(0, R_NONE,       32'h0,    0, 6'h00, 0, EXC_VEC, 0));
        rows.push_back(mk(0, R_EX,         32'h55,   0, 6'h3F, 0, EXC_VEC, 0)); // overrides ex
        rows.push_back(mk(0, R_EX,         0,        0, 6'h00, 1, EXC_VEC, 0));
        rows.push_back(mk(0, R_NONE,       0,        0, 6'h00, 0, EXC_VEC, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc
                || stall_timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL syscall[%0d]: got stall=%b flush=%b new_pc=%h tmo=%b, want stall=%b flush=%b new_pc=%h tmo=%b",
                         i, stall, flush, new_pc, stall_timeout, e.stall, e.flush, e.pc, e.tmo);
            end
        end
    endtask

    task automatic test_eret_deferred();
        row_t rows[$];
        exp_t e;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rows.push_back(mk(0, R_MEM, 32'he, 32'h00001234, 6'h1F, 0, 32'h0, 0));
        end
        rows.push_back(mk(0, R_NONE, 32'he, 32'h00001234, 6'h3F, 0, 32'h0, 0));
        rows.push_back(mk(0, R_NONE, 32'he, 32'h00005678, 6'h00, 1, 32'h00001234, 0));
        rows.push_back(mk(0, R_NONE, 0,     32'h00005678, 6'h00, 0, 32'h00001234, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc
                || stall_timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL eret[%0d]: got stall=%b flush=%b new_pc=%h tmo=%b, want stall=%b flush=%b new_pc=%h tmo=%b",
                         i, stall, flush, new_pc, stall_timeout, e.stall, e.flush, e.pc, e.tmo);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        do_reset();
        rows.push_back(mk(0, R_NONE, 32'h1, 0,            6'h3F, 0, 32'h0,   0));
        rows.push_back(mk(0, R_NONE, 32'h1, 0,            6'h00, 1, INT_VEC, 0));
        rows.push_back(mk(0, R_NONE, 32'h8, 0,            6'h3F, 0, INT_VEC, 0));
        rows.push_back(mk(0, R_NONE, 32'h8, 0,            6'h00, 1, EXC_VEC, 0));
        rows.push_back(mk(0, R_NONE, 32'he, 32'h0000ABCD, 6'h3F, 0, EXC_VEC, 0));
        rows.push_back(mk(0, R_NONE, 32'h0, 32'h0000ABCD, 6'h00, 1, 32'h0000ABCD, 0));
        rows.push_back(mk(0, R_NONE, 32'h0, 32'h0,        6'h00, 0, 32'h0000ABCD, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc
                || stall_timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got stall=%b flush=%b new_pc=%h tmo=%b, want stall=%b flush=%b new_pc=%h tmo=%b",
                         i, stall, flush, new_pc, stall_timeout, e.stall, e.flush, e.pc, e.tmo);
            end
        end
    endtask

    task automatic test_watchdog();
        row_t rows[$];
        exp_t e;
        do_reset();
        // Two 3-cycle stalls separated by a gap never reach the bound.
        for (int k = 0; k < 3; k++) rows.push_back(mk(0, R_EX, 0, 0, 6'h0F, 0, 0, 0));
        rows.push_back(mk(0, R_NONE, 0, 0, 6'h00, 0, 0, 0));
        for (int k = 0; k < 3; k++) rows.push_back(mk(0, R_EX, 0, 0, 6'h0F, 0, 0, 0));
        rows.push_back(mk(0, R_NONE, 0, 0, 6'h00, 0, 0, 0));
        // Flag becomes visible after the 4th consecutive stalled cycle.
        for (int k = 0; k < 4; k++) rows.push_back(mk(0, R_EX, 0, 0, 6'h0F, 0, 0, 0));
        for (int k = 0; k < 3; k++) rows.push_back(mk(0, R_EX, 0, 0, 6'h0F, 0, 0, 1));
        rows.push_back(mk(0, R_NONE, 0,     0, 6'h00, 0, 0,       1));
        rows.push_back(mk(0, R_NONE, 32'h8, 0, 6'h3F, 0, 0,       1));
        rows.push_back(mk(0, R_NONE, 0,     0, 6'h00, 1, EXC_VEC, 1));
        rows.push_back(mk(0, R_NONE, 0,     0, 6'h00, 0, EXC_VEC, 1));
        rows.push_back(mk(1, R_EX,   0,     0, 6'h00, 0, EXC_VEC, 1));
        rows.push_back(mk(0, R_NONE, 0,     0, 6'h00, 0, 32'h0,   0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc
                || stall_timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL watchdog[%0d]: got stall=%b flush=%b new_pc=%h tmo=%b, want stall=%b flush=%b new_pc=%h tmo=%b",
                         i, stall, flush, new_pc, stall_timeout, e.stall, e.flush, e.pc, e.tmo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_syscall();
        test_eret_deferred();
        test_back_to_back();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the five-stage core. It merges per-stage stall requests into the 6-bit stall vector consumed by the PC register and the inter-stage registers. It accepts exceptions from the MEM stage and sequences a one-cycle pipeline flush with a redirect PC. It also runs a stall watchdog that flags a pipeline stalled beyond a bound.

Parameters:
EBASE, 32'h00000000, exception base address
STALL_TIMEOUT, 1024, consecutive stalled RUN cycles before stall_timeout sets; legal range 2..65535
CNT_W, 16, watchdog counter width; must satisfy 2^CNT_W > STALL_TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous, active-high (`RstEnable = 1'b1)
stallreq_from_if  input  1  fetch memory not ready
stallreq_from_id  input  1  ID stage stall (load-use)
stallreq_from_ex  input  1  EX stage stall (multi-cycle mul/div)
stallreq_from_mem  input  1  MEM stage stall (data bus wait)
excepttype_i  input  32  exception code from MEM stage; 0 = none; held by source until flushed
cp0_epc_i  input  32  EPC value from CP0
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
flush  output  1  clear all pipeline registers, load new_pc into PC (registered)
new_pc  output  32  redirect target, valid when flush=1 (registered)
stall_timeout  output  1  sticky watchdog flag (registered)

Behaviour:
- Reset (rst=1 at posedge): state=RUN, flush=0, new_pc=0, watchdog count=0, stall_timeout=0. While rst=1, stall=6'b000000.
- States: RUN, FLUSH.
- RUN, stall vector (combinational from inputs). Highest-priority request wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000111
  - none: 6'b000000
- RUN, exception accept: excepttype_i!=0 and stallreq_from_mem=0.
  - Same cycle: stall=6'b111111, overriding all requests.
  - The vector is latched into new_pc at the edge, flush<=1, next state FLUSH.
- RUN, exception with stallreq_from_mem=1: not accepted. stall=6'b011111 and state stays RUN. Acceptance is deferred until mem stall drops.
- Vector select:
  - 32'h00000001 (interrupt): EBASE+32'h20
  - 32'h0000000e (eret): cp0_epc_i sampled in the accept cycle
  - 32'h00000008 / 0000000a / 0000000c / 0000000d: EBASE+32'h40
  - any other nonzero code: EBASE+32'h40
  - Additions are 32-bit and wrap.
- FLUSH (exactly one cycle):
  - flush=1, new_pc holds the latched vector, stall=6'b000000.
  - excepttype_i and all stall requests are ignored.
  - Next edge: flush<=0, state RUN. new_pc keeps its last value; consumers ignore it when flush=0.
- Back-to-back: an exception present in the first RUN cycle after FLUSH is accepted normally. The minimum spacing is therefore 2 cycles per exception.
- Watchdog:
  - The count increments on each RUN cycle with stall!=0. Accept cycles and FLUSH cycles clear it, as does any RUN cycle with stall=0.
  - When a stalled RUN cycle occurs with count==STALL_TIMEOUT-1, stall_timeout<=1. The count saturates and does not wrap.
  - stall_timeout clears only on rst. It has no effect on stall or flush.
- Reset mid-FLUSH or mid-stall: the next edge returns to the reset values. A pending exception is dropped unless the source re-presents it.

Test Plan:
- Reset, then all requests 0: stall=000000, flush=0, new_pc=0, stall_timeout=0; PC free-runs +4.
- Priority: stallreq_from_id=1 alone gives stall=000111. Add ex gives 001111. Add mem gives 011111. Drop all gives 000000 in the same cycle.
- Syscall accept with EBASE=0: excepttype_i=8 in cycle N gives stall=111111 in N, then in N+1 flush=1, new_pc=32'h40, stall=000000. In N+2, flush=0.
- Deferred eret: excepttype_i=0xe, cp0_epc_i=32'h00001234, stallreq_from_mem=1 for 3 cycles gives stall=011111 and no flush. Mem drops gives accept, then flush=1, new_pc=32'h00001234.
- Interrupt with EBASE=32'hBFC00200: new_pc=32'hBFC00220. A second exception right after FLUSH gives a second flush 2 cycles later.
- Watchdog with STALL_TIMEOUT=4: stallreq_from_ex held gives stall_timeout=1 after 4th stalled cycle. A 3-cycle stall followed by a gap and another 3-cycle stall never sets it. Only rst clears it.
